// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are active low, bit 6 = a ... bit 0 = g.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h7E;

  typedef enum int {
    SEG_G = 0,
    SEG_F = 1,
    SEG_E = 2,
    SEG_D = 3,
    SEG_C = 4,
    SEG_B = 5,
    SEG_A = 6
  } seg_bit_e;

  localparam logic [0:15][6:0] GLYPH = {
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low 7-segment glyph.
// With HEX_MODE=0 the codes 10..15 show a dash.
module seg_hex_decode
  import seg_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH[nibble];
    if (HEX_MODE == 0 && nibble > 4'd9)
      seg = SEG_DASH;
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode display driver with tear-free
// loading, blanking, blink, decimal points and dead time.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int HEX_MODE     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  localparam int NW = NUM_DIGITS;

  logic [PW-1:0] p;
  logic [IW-1:0] idx;
  logic [FW-1:0] fcnt, fcnt_d;
  logic          hidden, hidden_d;

  logic          pend_v;
  logic [DW-1:0] pend_dig;
  logic [NW-1:0] pend_blank, pend_blink, pend_dp;

  logic [DW-1:0] sh_dig, sh_dig_d;
  logic [NW-1:0] sh_blank, sh_blank_d;
  logic [NW-1:0] sh_blink, sh_blink_d;
  logic [NW-1:0] sh_dp, sh_dp_d;

  logic       last_p, last_i, dead, dark;
  logic [3:0] nibble;
  logic [6:0] glyph;

  // Shadow and blink phase are used in their next-state form so
  // digit 0 of a new frame already sees the committed value.
  always_comb begin
    last_p     = (p == PW'(SCAN_DIV - 1));
    last_i     = (idx == IW'(NUM_DIGITS - 1));
    sh_dig_d   = sh_dig;
    sh_blank_d = sh_blank;
    sh_blink_d = sh_blink;
    sh_dp_d    = sh_dp;
    fcnt_d     = fcnt;
    hidden_d   = hidden;
    if (frame_o) begin
      if (load_i) begin
        sh_dig_d   = digits_i;
        sh_blank_d = blank_i;
        sh_blink_d = blink_i;
        sh_dp_d    = dp_i;
      end else if (pend_v) begin
        sh_dig_d   = pend_dig;
        sh_blank_d = pend_blank;
        sh_blink_d = pend_blink;
        sh_dp_d    = pend_dp;
      end
      if (int'(fcnt) == BLINK_FRAMES - 1) begin
        fcnt_d   = '0;
        hidden_d = ~hidden;
      end else begin
        fcnt_d = fcnt + 1'b1;
      end
    end
    nibble = sh_dig_d[4*idx +: 4];
    dark   = sh_blank_d[idx] | (sh_blink_d[idx] & hidden_d);
    dead   = int'(p) < DEAD_CYCLES;
  end

  seg_hex_decode #(
    .HEX_MODE (HEX_MODE)
  ) u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p          <= '0;
      idx        <= '0;
      fcnt       <= '0;
      hidden     <= 1'b0;
      pend_v     <= 1'b0;
      pend_dig   <= '0;
      pend_blank <= '0;
      pend_blink <= '0;
      pend_dp    <= '0;
      sh_dig     <= '0;
      sh_blank   <= '0;
      sh_blink   <= '0;
      sh_dp      <= '0;
      seg_o      <= SEG_BLANK;
      dp_o       <= 1'b1;
      an_o       <= '1;
      frame_o    <= 1'b0;
    end else begin
      p <= last_p ? '0 : p + 1'b1;
      if (last_p)
        idx <= last_i ? '0 : idx + 1'b1;
      frame_o  <= last_p & last_i;
      fcnt     <= fcnt_d;
      hidden   <= hidden_d;
      sh_dig   <= sh_dig_d;
      sh_blank <= sh_blank_d;
      sh_blink <= sh_blink_d;
      sh_dp    <= sh_dp_d;
      if (frame_o) begin
        pend_v <= 1'b0;
      end else if (load_i) begin
        pend_v     <= 1'b1;
        pend_dig   <= digits_i;
        pend_blank <= blank_i;
        pend_blink <= blink_i;
        pend_dp    <= dp_i;
      end
      if (dead) begin
        an_o  <= '1;
        seg_o <= SEG_BLANK;
        dp_o  <= 1'b1;
      end else begin
        an_o  <= ~(NW'(1) << idx);
        seg_o <= dark ? SEG_BLANK : glyph;
        dp_o  <= dark | ~sh_dp_d[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed plus randomized check of seg_scan_driver against a
// cycle-count based model (HEX_MODE 1 and 0 side by side).
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DC = 1;
  localparam int BF = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] digits_i = '0;
  logic [3:0]  blank_i = '0;
  logic [3:0]  blink_i = '0;
  logic [3:0]  dp_i = '0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fr_a, fr_b;
  logic [3:0] an_a, an_b;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC),
    .BLINK_FRAMES(BF), .HEX_MODE(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .load_i(load_i),
    .digits_i(digits_i), .blank_i(blank_i),
    .blink_i(blink_i), .dp_i(dp_i),
    .seg_o(seg_a), .dp_o(dp_a), .an_o(an_a), .frame_o(fr_a)
  );

  seg_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC),
    .BLINK_FRAMES(BF), .HEX_MODE(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_i(load_i),
    .digits_i(digits_i), .blank_i(blank_i),
    .blink_i(blink_i), .dp_i(dp_i),
    .seg_o(seg_b), .dp_o(dp_b), .an_o(an_b), .frame_o(fr_b)
  );

  logic [6:0] gl [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  // model: last requested load and the value visible this frame
  logic [15:0] req_dig, vis_dig;
  logic [3:0]  req_bk, req_bl, req_dp;
  logic [3:0]  vis_bk, vis_bl, vis_dp;

  logic [6:0] e_seg, e_seg0;
  logic [3:0] e_an;
  logic       e_dp, e_fr;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    req_dig = '0; req_bk = '0; req_bl = '0; req_dp = '0;
    vis_dig = '0; vis_bk = '0; vis_bl = '0; vis_dp = '0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_seg"}, 16'(seg_a), 16'h7F);
    chk({tag, "_an"}, 16'(an_a), 16'hF);
    chk({tag, "_dp"}, 16'(dp_a), 16'h1);
    chk({tag, "_frame"}, 16'(fr_a), 16'h0);
    chk({tag, "_seg0"}, 16'(seg_b), 16'h7F);
    chk({tag, "_an0"}, 16'(an_b), 16'hF);
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic cyc(input bit ld, input logic [15:0] dg,
                     input logic [3:0] bk, input logic [3:0] bl,
                     input logic [3:0] dq);
    int pp, id, hid;
    logic [3:0] nib;
    logic dark;
    load_i = ld; digits_i = dg;
    blank_i = bk; blink_i = bl; dp_i = dq;
    if (ld) begin
      req_dig = dg; req_bk = bk; req_bl = bl; req_dp = dq;
    end
    if (n > 0 && n % FRAME == 0) begin
      vis_dig = req_dig; vis_bk = req_bk;
      vis_bl = req_bl; vis_dp = req_dp;
    end
    pp  = n % SD;
    id  = (n / SD) % ND;
    hid = ((n / FRAME) / BF) % 2;
    nib = 4'((vis_dig >> (4 * id)) & 16'hF);
    dark = vis_bk[id] | (vis_bl[id] & (hid == 1));
    e_fr = ((n + 1) % FRAME == 0);
    if (pp < DC) begin
      e_an = 4'hF; e_seg = 7'h7F; e_seg0 = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an = ~(4'b0001 << id);
      e_seg = dark ? 7'h7F : gl[nib];
      e_seg0 = dark ? 7'h7F : (nib > 4'd9 ? 7'h7E : gl[nib]);
      e_dp = dark ? 1'b1 : ~vis_dp[id];
    end
    @(posedge clk);
    n++;
    @(negedge clk);
    load_i = 1'b0;
    chk("seg", 16'(seg_a), 16'(e_seg));
    chk("an", 16'(an_a), 16'(e_an));
    chk("dp", 16'(dp_a), 16'(e_dp));
    chk("frame", 16'(fr_a), 16'(e_fr));
    chk("seg_hex0", 16'(seg_b), 16'(e_seg0));
    chk("an_hex0", 16'(an_b), 16'(e_an));
    chk("dp_hex0", 16'(dp_b), 16'(e_dp));
    chk("frame_hex0", 16'(fr_b), 16'(e_fr));
    chk("an_single", 16'($countones(~an_a) <= 1), 16'h1);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      cyc(1'b0, 16'($urandom), 4'($urandom),
          4'($urandom), 4'($urandom));
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;
    model_reset();

    cyc(1'b1, 16'h3210, 4'h0, 4'h0, 4'h0);
    idle(40);

    cyc(1'b1, 16'hFEDC, 4'h0, 4'h0, 4'h0);
    idle(36);

    while (n % FRAME != 8) idle(1);
    cyc(1'b1, 16'h9876, 4'h0, 4'h0, 4'h0);
    idle(30);

    while (n % FRAME != 0) idle(1);
    cyc(1'b1, 16'h5A4B, 4'h0, 4'h0, 4'h0);
    idle(20);

    cyc(1'b1, 16'h3210, 4'b1000, 4'b0001, 4'b0010);
    idle(110);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 7) == 0, 16'($urandom),
          4'($urandom), 4'($urandom), 4'($urandom));

    cyc(1'b1, 16'hABCD, 4'h0, 4'h0, 4'hF);
    while (n % FRAME != 10) idle(1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("async_rst");
    @(negedge clk);
    check_reset_outs("in_rst");
    rst_n = 1'b1;
    model_reset();
    idle(2);
    chk("post_rst_seg", 16'(seg_a), 16'h01);
    chk("post_rst_an", 16'(an_a), 16'hE);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
- Latches a packed nibble vector and scans one digit per slot.
- Adds decode, per-digit blanking and blink, decimal point, and anti-ghosting dead time.
- Replaces the single-digit combinational decoder; feeds the board's display for score and card values.

Parameters:
- NUM_DIGITS, 4: digits scanned; must be ≥1.
- SCAN_DIV, 50000: clk cycles per digit slot; must be ≥2.
- DEAD_CYCLES, 2: cycles at slot start with all anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 64: full frames per blink half-period.
- HEX_MODE, 1: 1 = codes A–F shown as hex glyphs; 0 = codes 10–15 shown as "-".

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_i  in  1  request to capture digits_i, blank_i, blink_i, dp_i.
- digits_i  in  4*NUM_DIGITS  nibble k = digit k; digit 0 is rightmost.
- blank_i  in  NUM_DIGITS  1 = digit k dark.
- blink_i  in  NUM_DIGITS  1 = digit k blinks.
- dp_i  in  NUM_DIGITS  1 = decimal point k lit.
- seg_o  out  7  active-low segments: [6]=a top, [5]=b upper-right, [4]=c lower-right, [3]=d bottom, [2]=e lower-left, [1]=f upper-left, [0]=g middle.
- dp_o  out  1  active-low decimal point.
- an_o  out  NUM_DIGITS  active-low anode enables; at most one low at any time.
- frame_o  out  1  one-cycle pulse when the digit index wraps NUM_DIGITS-1 → 0.

Behaviour:
- Reset (async assert, sync release):
  - seg_o=7'h7F, dp_o=1, an_o all 1, frame_o=0.
  - Prescaler p=0, index idx=0, blink phase=visible, frame counter=0.
  - Pending and shadow registers all 0, pending_valid=0.
- Prescaler:
  - p counts 0..SCAN_DIV-1 and wraps to 0.
  - At p=SCAN_DIV-1, idx advances (NUM_DIGITS-1 wraps to 0).
  - On the idx wrap, frame_o=1 for that single cycle.
- Load, tear-free:
  - load_i captures its inputs into pending and sets pending_valid.
  - Pending commits to shadow on the frame_o cycle, then pending_valid clears.
  - Repeated loads before commit: last one wins.
  - load_i on the frame_o cycle: inputs go directly to shadow, pending_valid stays 0.
- Blink:
  - Frame counter counts frame_o pulses 0..BLINK_FRAMES-1.
  - On wrap, blink phase toggles.
  - Phase=hidden darkens every digit with shadow blink bit set.
- Outputs (all registered; one-cycle latency from p/idx):
  - p<DEAD_CYCLES: an_o all 1, seg_o=7'h7F, dp_o=1.
  - Otherwise: an_o[idx]=0.
  - seg_o=decode(shadow digit idx), unless blank set, or blink set with phase hidden; then seg_o=7'h7F and dp_o=1.
  - When lit, dp_o=~dp[idx].
- Decode, active low, order a..g:
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04.
  - HEX_MODE=1: A=08, b=60, C=31, d=42, E=30, F=38.
  - HEX_MODE=0: codes 10–15 = 7E.
- Mid-operation reset: outputs return to reset values immediately (asynchronously), and scanning restarts at digit 0.
- NUM_DIGITS=1: idx stays 0; frame_o pulses every SCAN_DIV cycles.

Decomposition:
- Package seg_pkg holds:
  - Segment constants SEG_BLANK=7'h7F and SEG_DASH=7'h7E.
  - The 16-entry glyph constant table.
  - Segment bit-index constants SEG_A..SEG_G.
- Sub-module seg_hex_decode (combinational, HEX_MODE parameter): nibble → 7-bit active-low pattern.
- Prescaler, index, blink and load logic stay in the top.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2, HEX_MODE=1):
- Reset, then load_i with digits_i=16'h3210, blank/blink/dp=0 → after the first frame_o, for each slot at p=1..3 (registered, seen +1 cycle):
  - an_o=1110 with seg_o=01, then 1101 with 4F, 1011 with 12, 0111 with 06.
  - an_o=1111 and seg_o=7F in each dead cycle.
- Load digits_i=16'hFEDC → glyphs 31, 42, 30, 38; rerun with HEX_MODE=0 → all four 7E.
- Load mid-frame (idx=2) with new value → still-scanning digits 2–3 keep the old shadow; new value appears only after frame_o; load on the frame_o cycle itself → new value shown from digit 0 of the next frame.
- blink_i=4'b0001 → digit 0 lit for frames 0–1, dark (seg 7F, an_o still low) for frames 2–3, lit for 4–5; blank_i=4'b1000 → digit 3 always 7F; dp_i=4'b0010 → dp_o=0 only while an_o=1101 and lit.
- Assert rst_n=0 mid-slot (idx=2, p=2) → seg_o=7F, an_o=1111, dp_o=1 in the same cycle without a clock edge; after release, first lit slot is digit 0, with shadow cleared (glyph 01).
- Throughout all runs → an_o never has more than one bit 0, and frame_o occurs exactly every 16 cycles.
